// File: rtl/modinv.sv
// Sequential inverse mod 29 via a^27 (Fermat), one shared mod-29 multiplier.
// Fixed 10-cycle latency from capture to done; start is ignored while busy.
`timescale 1ns/1ps
module modinv (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] a,
  output logic       busy,
  output logic       done,
  output logic [4:0] inv,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SQR, MUL} state_t;

  localparam logic [4:0] EXP = 5'd27;

  // 32 = 3 (mod 29): fold the high bits twice, then one conditional subtract.
  function automatic logic [4:0] mulmod29(input logic [4:0] x, input logic [4:0] y);
    logic [9:0] p;
    logic [6:0] f1;
    logic [5:0] f2;
    logic [5:0] d;
    p  = {5'd0, x} * {5'd0, y};
    f1 = {2'd0, p[9:5]} * 7'd3 + {2'd0, p[4:0]};
    f2 = {4'd0, f1[6:5]} * 6'd3 + {1'b0, f1[4:0]};
    d  = f2 - 6'd29;
    return (f2 >= 6'd29) ? d[4:0] : f2[4:0];
  endfunction

  state_t     r_state;
  logic [4:0] r_r;
  logic [2:0] r_idx;
  logic [4:0] r_base;
  logic       r_busy;
  logic       r_done;
  logic [4:0] r_inv;
  logic       r_err;

  state_t     w_state;
  logic [4:0] w_r;
  logic [2:0] w_idx;
  logic [4:0] w_base;
  logic       w_busy;
  logic       w_done;
  logic [4:0] w_inv;
  logic       w_err;
  logic [4:0] w_sq;
  logic [4:0] w_mb;
  logic [4:0] w_mul_r;

  assign w_sq    = mulmod29(r_r, r_r);
  assign w_mb    = mulmod29(r_r, r_base);
  assign w_mul_r = EXP[r_idx] ? w_mb : r_r;

  always_comb begin
    w_state = r_state;
    w_r     = r_r;
    w_idx   = r_idx;
    w_base  = r_base;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_inv   = r_inv;
    w_err   = r_err;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_base  = (a >= 5'd29) ? (a - 5'd29) : a;
          w_r     = 5'd1;
          w_idx   = 3'd4;
          w_busy  = 1'b1;
          w_state = SQR;
        end
      end
      SQR: begin
        w_r     = w_sq;
        w_state = MUL;
      end
      MUL: begin
        w_r = w_mul_r;
        if (r_idx == 3'd0) begin
          w_inv   = w_mul_r;
          w_err   = (r_base == 5'd0);
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else begin
          w_idx   = r_idx - 3'd1;
          w_state = SQR;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_r     <= 5'd1;
      r_idx   <= 3'd0;
      r_base  <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_inv   <= 5'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_r     <= w_r;
      r_idx   <= w_idx;
      r_base  <= w_base;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_inv   <= w_inv;
      r_err   <= w_err;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign inv  = r_inv;
  assign err  = r_err;

endmodule
